// File: rtl/bp_pkg.sv
// Shared definitions for the LDPC belief-propagation decoder.
package bp_pkg;

    localparam int DEF_N_COLS = 6;
    localparam int DEF_LLR_W  = 8;
    localparam int SAT_MAX    = 2 ** (DEF_LLR_W - 1) - 1;
    localparam int COL_W      = $clog2(DEF_N_COLS);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WRITE
    } row_state_t;

endpackage

// File: rtl/bp_abs_sat.sv
// Splits a signed LLR into its sign bit and a magnitude saturated to 2^(W-1)-1.
module bp_abs_sat #(
    parameter int W = 8
) (
    input  logic [W-1:0] llr,
    output logic         sign,
    output logic [W-1:0] mag
);

    localparam logic [W-1:0] MAG_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] NEG_MIN = {1'b1, {(W-1){1'b0}}};

    always_comb begin
        sign = llr[W-1];
        if (!llr[W-1])
            mag = llr;
        else if (llr == NEG_MIN)
            mag = MAG_MAX;
        else
            mag = -llr;
    end

endmodule

// File: rtl/bp_row_processor.sv
// Min-sum check-node update for one H-matrix row: serial scan of LLRs, then serial message write.
module bp_row_processor
    import bp_pkg::*;
#(
    parameter int N_COLS = DEF_N_COLS,
    parameter int LLR_W  = DEF_LLR_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [N_COLS-1:0]       row_mask,
    input  logic [N_COLS*LLR_W-1:0] llr_in,
    output logic [N_COLS*LLR_W-1:0] msg_out,
    output logic                    done,
    output logic                    busy
);

    localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam logic [CW-1:0]    LAST_COL = CW'(N_COLS - 1);
    localparam logic [LLR_W-1:0] MAG_MAX  = {1'b0, {(LLR_W-1){1'b1}}};

    row_state_t state, state_next;

    logic [CW-1:0]           col;
    logic [N_COLS-1:0]       mask_q;
    logic [N_COLS*LLR_W-1:0] llr_q;
    logic [N_COLS*LLR_W-1:0] msg_q;
    logic [LLR_W-1:0]        min1, min2;
    logic [CW-1:0]           idx;
    logic                    sgn;
    logic                    done_q;

    logic [LLR_W-1:0] cur_llr, cur_mag, wr_mag, wr_val;
    logic             cur_sign, last_col;

    assign cur_llr  = llr_q[int'(col)*LLR_W +: LLR_W];
    assign last_col = (col == LAST_COL);

    bp_abs_sat #(.W(LLR_W)) u_abs_sat (
        .llr  (cur_llr),
        .sign (cur_sign),
        .mag  (cur_mag)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        unique case (state)
            IDLE:  if (start)    state_next = SCAN;
            SCAN:  if (last_col) state_next = WRITE;
            WRITE: if (last_col) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    // The column holding the row minimum receives the second minimum; all others get the minimum.
    always_comb begin
        wr_mag = (col == idx) ? min2 : min1;
        wr_val = (sgn ^ cur_sign) ? -wr_mag : wr_mag;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col    <= '0;
            mask_q <= '0;
            llr_q  <= '0;
            msg_q  <= '0;
            min1   <= '0;
            min2   <= '0;
            idx    <= '0;
            sgn    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mask_q <= row_mask;
                        llr_q  <= llr_in;
                        msg_q  <= '0;
                        done_q <= 1'b0;
                        col    <= '0;
                        min1   <= MAG_MAX;
                        min2   <= MAG_MAX;
                        idx    <= '0;
                        sgn    <= 1'b0;
                    end
                end
                SCAN: begin
                    if (mask_q[col]) begin
                        if (cur_mag < min1) begin
                            min2 <= min1;
                            min1 <= cur_mag;
                            idx  <= col;
                        end else if (cur_mag < min2) begin
                            min2 <= cur_mag;
                        end
                        sgn <= sgn ^ cur_sign;
                    end
                    col <= last_col ? '0 : col + CW'(1);
                end
                WRITE: begin
                    msg_q[int'(col)*LLR_W +: LLR_W] <= mask_q[col] ? wr_val : '0;
                    col <= last_col ? '0 : col + CW'(1);
                    if (last_col)
                        done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign msg_out = msg_q;
    assign done    = done_q;

endmodule

// File: tb/tb_bp_row_processor.sv
// Bench for bp_row_processor: directed min-sum cases, handshake/reset corners, random rows vs a model.
module tb_bp_row_processor;

    localparam int N = 6;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [N-1:0]   row_mask = '0;
    logic [N*W-1:0] llr_in = '0;
    logic [N*W-1:0] msg_out;
    logic           done;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;

    bp_row_processor #(.N_COLS(N), .LLR_W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .row_mask (row_mask),
        .llr_in   (llr_in),
        .msg_out  (msg_out),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pk(input int v0, input int v1, input int v2,
                                          input int v3, input int v4, input int v5);
        logic [7:0] b0, b1, b2, b3, b4, b5;
        b0 = v0[7:0]; b1 = v1[7:0]; b2 = v2[7:0];
        b3 = v3[7:0]; b4 = v4[7:0]; b5 = v5[7:0];
        return {b5, b4, b3, b2, b1, b0};
    endfunction

    // Each active column gets the sign product and minimum magnitude over the *other* active columns.
    function automatic logic [N*W-1:0] model(input logic [N-1:0] mask, input logic [N*W-1:0] llr);
        logic [N*W-1:0]   res;
        logic signed [7:0] b;
        logic [7:0]       o;
        int a, m, mn, s;
        res = '0;
        for (int j = 0; j < N; j++) begin
            if (mask[j]) begin
                mn = 127;
                s  = 0;
                for (int k = 0; k < N; k++) begin
                    if (k != j && mask[k]) begin
                        b = llr[k*W +: W];
                        a = b;
                        m = (a < 0) ? -a : a;
                        if (m > 127) m = 127;
                        if (m < mn) mn = m;
                        if (a < 0) s = s ^ 1;
                    end
                end
                a = (s != 0) ? -mn : mn;
                o = a[7:0];
                res[j*W +: W] = o;
            end
        end
        return res;
    endfunction

    // Called just after a rising edge; returns msg_out once done rises.
    task automatic run_row(input logic [N-1:0] mask, input logic [N*W-1:0] llr, input string tag,
                           input bit repulse, output logic [N*W-1:0] got);
        logic [N*W-1:0] exp;
        int n;
        exp      = model(mask, llr);
        row_mask = mask;
        llr_in   = llr;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        llr_in   = {$urandom, $urandom};
        row_mask = N'($urandom);
        check({tag, "_done_low"}, 64'(done), 64'd0);
        check({tag, "_busy_high"}, 64'(busy), 64'd1);
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (repulse && n == 3) begin
                start  = 1'b1;
                llr_in = {$urandom, $urandom};
                row_mask = N'($urandom);
            end
            if (repulse && n == 4) start = 1'b0;
            if (n == 9)
                check({tag, "_partial"}, 64'(msg_out), 64'(exp & {{(3*W){1'b0}}, {(3*W){1'b1}}}));
            if (done) break;
        end
        check({tag, "_latency"}, 64'(n), 64'd12);
        check({tag, "_busy_low"}, 64'(busy), 64'd0);
        check({tag, "_msg"}, 64'(msg_out), 64'(exp));
        got = msg_out;
    endtask

    initial begin
        logic [N*W-1:0] got, llr;
        logic [N-1:0]   mask;
        int n;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_msg", 64'(msg_out), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_row(6'b111111, pk(5, -3, 7, 2, -9, 4), "basic", 1'b0, got);
        check("basic_const", 64'(got), 64'(pk(2, -2, 2, 3, -2, 2)));

        run_row(6'b001011, pk(-4, 6, 99, -1, 99, 99), "masked", 1'b0, got);
        check("masked_const", 64'(got), 64'(pk(-1, 1, 0, -4, 0, 0)));

        run_row(6'b111111, pk(-128, 3, 3, 100, 50, 60), "sat_tie", 1'b0, got);
        check("sat_tie_const", 64'(got), 64'(pk(3, -3, -3, -3, -3, -3)));

        run_row(6'b000100, pk(11, -7, -20, 33, 1, -2), "single", 1'b0, got);
        check("single_const", 64'(got), 64'(pk(0, 0, 127, 0, 0, 0)));

        run_row(6'b000000, pk(11, -7, -20, 33, 1, -2), "empty", 1'b0, got);
        check("empty_const", 64'(got), 64'd0);

        // Start during SCAN must be ignored: done stays high and the result is unchanged.
        llr = pk(-50, 20, 8, -8, 90, -1);
        run_row(6'b111111, llr, "repulse", 1'b1, got);
        repeat (14) @(posedge clk);
        #1;
        check("repulse_done_held", 64'(done), 64'd1);
        check("repulse_msg_held", 64'(msg_out), 64'(model(6'b111111, llr)));

        // Back-to-back: start accepted while done is high (done_low checked inside run_row).
        run_row(6'b110110, pk(9, -9, 4, 4, -6, 127), "b2b", 1'b0, got);

        // Reset in the middle of WRITE aborts the request.
        row_mask = 6'b111111;
        llr_in   = pk(1, 2, 3, 4, 5, 6);
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_msg", 64'(msg_out), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        n = 0;
        repeat (16) begin
            @(posedge clk); #1;
            if (done || busy) n++;
        end
        check("abort_quiet", 64'(n), 64'd0);

        for (int t = 0; t < 40; t++) begin
            mask = N'($urandom);
            if (t % 5 == 0) mask = '1;
            for (int j = 0; j < N; j++) begin
                case ($urandom_range(0, 3))
                    0: llr[j*W +: W] = 8'h80;
                    1: llr[j*W +: W] = 8'($urandom_range(0, 6));
                    2: llr[j*W +: W] = -8'($urandom_range(0, 6));
                    default: llr[j*W +: W] = 8'($urandom);
                endcase
            end
            run_row(mask, llr, "rand", 1'b0, got);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
